perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, the number of independent event counter channels (legal 1..32).
REQ-002 SHALL have parameter CNT_W, default 32, the counter width in bits (legal 4..64).
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port event_i  input  NUM_CH  per-channel event pulse, one count per asserted cycle.
REQ-006 SHALL have port enable_i  input  NUM_CH  per-channel count enable.
REQ-007 SHALL have port sat_mode_i  input  NUM_CH  per-channel mode: 1 = saturate, 0 = wrap.
REQ-008 SHALL have port freeze_i  input  1  global count inhibit.
REQ-009 SHALL have port clear_i  input  NUM_CH  per-channel synchronous clear of the counter and its overflow flag.
REQ-010 SHALL have port snap_i  input  1  capture all live counters into shadow registers.
REQ-011 SHALL have port rd_req_i  input  1  read request.
REQ-012 SHALL have port rd_sel_i  input  $clog2(NUM_CH) (minimum 1)  read channel index.
REQ-013 SHALL have port rd_src_i  input  1  read source: 0 = live counter, 1 = shadow register.
REQ-014 SHALL have port rd_valid_o  output  1  read data valid.
REQ-015 SHALL have port rd_data_o  output  CNT_W  read data.
REQ-016 SHALL have port rd_ovf_o  output  1  overflow flag of the channel that was read.
REQ-017 SHALL have port ovf_o  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-018 Channel i SHALL increment by 1 in a cycle only when event_i[i], enable_i[i] and !freeze_i are all asserted and clear_i[i] is not.
REQ-019 Wrap mode: at count 2^CNT_W-1, an increment SHALL give 0 and set ovf_o[i].
REQ-020 Saturate mode: at count 2^CNT_W-1, an increment SHALL hold the count and set ovf_o[i].
REQ-021 ovf_o[i] SHALL stay set until clear_i[i] or reset.
REQ-022 clear_i[i] SHALL take priority over an increment in the same cycle: the next count is 0 and ovf_o[i] is 0.
REQ-023 snap_i SHALL copy the pre-edge live value of every channel, and its overflow flag, into the shadow registers in one cycle.
REQ-024 When snap_i and clear_i[i] occur together, shadow i SHALL receive the pre-clear value and live i SHALL become 0.
REQ-025 When snap_i and an increment occur together, shadow i SHALL receive the pre-increment value.
REQ-026 A read sampled on edge N SHALL assert rd_valid_o for exactly the cycle after edge N (latency 1).
REQ-027 That read SHALL return the pre-edge-N value of the selected source and its flag.
REQ-028 rd_req_i SHALL be accepted every cycle, giving back-to-back valid responses with no stall.
REQ-029 rd_sel_i >= NUM_CH SHALL return rd_data_o = 0 and rd_ovf_o = 0 with rd_valid_o still asserted.
REQ-030 rd_data_o and rd_ovf_o SHALL be 0 whenever rd_valid_o is 0.
REQ-031 A change of sat_mode_i SHALL affect only subsequent increments and SHALL NOT alter the stored count.

Reset
REQ-032 Asserting rst low SHALL immediately, without waiting for clk, zero all counters, shadow registers, ovf_o, rd_valid_o, rd_data_o and rd_ovf_o.
REQ-033 Reset asserted mid-read SHALL drop rd_valid_o at once; no response to the pending request SHALL appear after reset is released.
REQ-034 Counting SHALL resume on the first rising edge after rst is released high.

Verification
REQ-035 CNT_W=4, channel 0 in wrap mode, 17 event cycles -> count 1, ovf_o[0]=1.
REQ-036 CNT_W=4, channel 1 in saturate mode, 20 event cycles -> count 15, ovf_o[1]=1; then clear_i[1] -> count 0, ovf_o[1]=0.
REQ-037 Channel 2 at count 5 with snap_i, clear_i[2] and an event in the same cycle -> shadow 5, live 0; next-cycle read with rd_src_i=1 -> rd_data_o=5.
REQ-038 freeze_i high for 10 cycles with all events active -> all counts unchanged; reads on 3 consecutive cycles -> 3 consecutive rd_valid_o pulses with correct data.
REQ-039 NUM_CH=6, read with rd_sel_i=7 -> rd_valid_o=1, rd_data_o=0, rd_ovf_o=0.
REQ-040 rst driven low between clock edges with a read pending -> all outputs 0 before the next edge; no rd_valid_o after release.

Source files
------------

// File: rtl/perf_counter_bank.sv
// ---------------------------------------------------------------------------
// perf_counter_bank
//   Bank of NUM_CH independent event counters, each CNT_W bits wide, with a
//   per-channel wrap/saturate mode, sticky overflow flags, a global freeze,
//   per-channel synchronous clear and a one-shot snapshot into shadow
//   registers. A single read port returns either the live or the shadow
//   value of one channel one cycle after the request.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   event_i      per-channel event pulse (one count per asserted cycle)
//   enable_i     per-channel count enable
//   sat_mode_i   per-channel mode: 1 = saturate, 0 = wrap
//   freeze_i     global count inhibit
//   clear_i      per-channel synchronous clear of count and overflow flag
//   snap_i       copy every live counter and flag into its shadow register
//   rd_req_i     read request, accepted every cycle
//   rd_sel_i     read channel index
//   rd_src_i     read source: 0 = live, 1 = shadow
//   rd_valid_o   read response valid (one cycle after the request)
//   rd_data_o    read data, 0 when not valid or index out of range
//   rd_ovf_o     overflow flag of the channel read
//   ovf_o        sticky per-channel overflow flags
// ---------------------------------------------------------------------------

// One counter channel: live count, sticky overflow and its shadow copy.
module perf_counter_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clear,
    input  logic             i_sat,
    input  logic             i_snap,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_shd_cnt,
    output logic             o_shd_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] r_shd_cnt;
    logic             r_shd_ovf;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_shd_cnt <= '0;
            r_shd_ovf <= 1'b0;
        end else begin
            // Shadow takes the pre-edge value, so a same-cycle clear or
            // increment is not visible in the snapshot.
            if (i_snap) begin
                r_shd_cnt <= r_cnt;
                r_shd_ovf <= r_ovf;
            end
            if (i_clear) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (i_inc) begin
                if (w_at_max) begin
                    r_ovf <= 1'b1;
                    if (!i_sat)
                        r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_cnt     = r_cnt;
    assign o_ovf     = r_ovf;
    assign o_shd_cnt = r_shd_cnt;
    assign o_shd_ovf = r_shd_ovf;

endmodule

module perf_counter_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] event_i,
    input  logic [NUM_CH-1:0] enable_i,
    input  logic [NUM_CH-1:0] sat_mode_i,
    input  logic              freeze_i,
    input  logic [NUM_CH-1:0] clear_i,
    input  logic              snap_i,
    input  logic              rd_req_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    input  logic              rd_src_i,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              rd_ovf_o,
    output logic [NUM_CH-1:0] ovf_o
);

    logic [NUM_CH-1:0]            w_inc;
    logic [NUM_CH-1:0][CNT_W-1:0] w_live;
    logic [NUM_CH-1:0][CNT_W-1:0] w_shd;
    logic [NUM_CH-1:0]            w_live_ovf;
    logic [NUM_CH-1:0]            w_shd_ovf;
    logic [CNT_W-1:0]             w_rd_data;
    logic                         w_rd_ovf;

    logic                         r_rd_valid;
    logic [CNT_W-1:0]             r_rd_data;
    logic                         r_rd_ovf;

    // Clear priority is resolved inside each channel.
    assign w_inc = event_i & enable_i & {NUM_CH{~freeze_i}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_counter_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (w_inc[g]),
            .i_clear   (clear_i[g]),
            .i_sat     (sat_mode_i[g]),
            .i_snap    (snap_i),
            .o_cnt     (w_live[g]),
            .o_ovf     (w_live_ovf[g]),
            .o_shd_cnt (w_shd[g]),
            .o_shd_ovf (w_shd_ovf[g])
        );
    end

    // Select-by-match: an index with no matching channel falls through to
    // the zero default, which covers rd_sel_i >= NUM_CH.
    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                w_rd_data = rd_src_i ? w_shd[i]     : w_live[i];
                w_rd_ovf  = rd_src_i ? w_shd_ovf[i] : w_live_ovf[i];
            end
        end
    end

    // Data is zeroed on idle cycles so the bus is 0 whenever valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_rd_valid <= rd_req_i;
            r_rd_data  <= rd_req_i ? w_rd_data : '0;
            r_rd_ovf   <= rd_req_i & w_rd_ovf;
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;
    assign rd_ovf_o   = r_rd_ovf;
    assign ovf_o      = w_live_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with NUM_CH=6, CNT_W=4.
module tb_perf_counter_bank;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 4;
    localparam int SEL_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] event_i = '0;
    logic [NUM_CH-1:0] enable_i = '0;
    logic [NUM_CH-1:0] sat_mode_i = '0;
    logic              freeze_i = 1'b0;
    logic [NUM_CH-1:0] clear_i = '0;
    logic              snap_i = 1'b0;
    logic              rd_req_i = 1'b0;
    logic [SEL_W-1:0]  rd_sel_i = '0;
    logic              rd_src_i = 1'b0;
    logic              rd_valid_o;
    logic [CNT_W-1:0]  rd_data_o;
    logic              rd_ovf_o;
    logic [NUM_CH-1:0] ovf_o;

    int checks = 0;
    int failures = 0;

    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .event_i    (event_i),
        .enable_i   (enable_i),
        .sat_mode_i (sat_mode_i),
        .freeze_i   (freeze_i),
        .clear_i    (clear_i),
        .snap_i     (snap_i),
        .rd_req_i   (rd_req_i),
        .rd_sel_i   (rd_sel_i),
        .rd_src_i   (rd_src_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .rd_ovf_o   (rd_ovf_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single read: request for one edge, then check the response cycle.
    task automatic rd(input string tag, input logic [SEL_W-1:0] sel, input logic src,
                      input logic [CNT_W-1:0] exp_d, input logic exp_o);
        rd_req_i = 1'b1;
        rd_sel_i = sel;
        rd_src_i = src;
        step(1);
        rd_req_i = 1'b0;
        chk({tag, "_valid"}, 64'(rd_valid_o), 64'(1'b1));
        chk({tag, "_data"},  64'(rd_data_o),  64'(exp_d));
        chk({tag, "_ovf"},   64'(rd_ovf_o),   64'(exp_o));
    endtask

    initial begin
        // Reset asserted before any clock edge: outputs must clear at once.
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_data",  64'(rd_data_o),  64'd0);
        chk("rst_rdovf", 64'(rd_ovf_o),   64'd0);
        chk("rst_ovf",   64'(ovf_o),      64'd0);
        step(1);
        #2 rst = 1'b1;
        step(1);

        enable_i   = '1;
        sat_mode_i = 6'b000010;

        // ch0 wrap: 17 events -> 16 reaches 0 with overflow, 17th -> 1.
        event_i = 6'b000001;
        step(17);
        event_i = '0;
        rd("wrap_ch0", 3'd0, 1'b0, 4'd1, 1'b1);
        chk("wrap_ovf0", 64'(ovf_o[0]), 64'd1);

        // ch1 saturate: 20 events -> holds at 15 with overflow.
        event_i = 6'b000010;
        step(20);
        event_i = '0;
        rd("sat_ch1", 3'd1, 1'b0, 4'd15, 1'b1);
        clear_i = 6'b000010;
        step(1);
        clear_i = '0;
        rd("clr_ch1", 3'd1, 1'b0, 4'd0, 1'b0);
        chk("clr_ovf", 64'(ovf_o), 64'b000001);

        // ch2 to 5, then snap + clear + event together.
        event_i = 6'b000100;
        step(5);
        snap_i  = 1'b1;
        clear_i = 6'b000100;
        step(1);
        snap_i  = 1'b0;
        clear_i = '0;
        event_i = '0;
        rd("snap_shd2",  3'd2, 1'b1, 4'd5, 1'b0);
        rd("snap_live2", 3'd2, 1'b0, 4'd0, 1'b0);
        rd("snap_shd0",  3'd0, 1'b1, 4'd1, 1'b1);

        // Freeze with every event active: nothing moves.
        freeze_i = 1'b1;
        event_i  = '1;
        step(10);
        freeze_i = 1'b0;
        event_i  = '0;
        chk("frz_ovf", 64'(ovf_o), 64'b000001);

        // Three back-to-back reads.
        rd_req_i = 1'b1;
        rd_sel_i = 3'd0; rd_src_i = 1'b0;
        step(1);
        chk("b2b0_valid", 64'(rd_valid_o), 64'd1);
        chk("b2b0_data",  64'(rd_data_o),  64'd1);
        rd_sel_i = 3'd2; rd_src_i = 1'b1;
        step(1);
        chk("b2b1_valid", 64'(rd_valid_o), 64'd1);
        chk("b2b1_data",  64'(rd_data_o),  64'd5);
        rd_sel_i = 3'd3; rd_src_i = 1'b0;
        step(1);
        chk("b2b2_valid", 64'(rd_valid_o), 64'd1);
        chk("b2b2_data",  64'(rd_data_o),  64'd0);
        rd_req_i = 1'b0;
        step(1);
        chk("idle_valid", 64'(rd_valid_o), 64'd0);
        chk("idle_data",  64'(rd_data_o),  64'd0);

        // Out-of-range index.
        rd("oor_sel7", 3'd7, 1'b0, 4'd0, 1'b0);

        // Mode change does not touch the stored count.
        event_i = 6'b000010;
        step(3);
        event_i = '0;
        sat_mode_i = '0;
        step(1);
        rd("mode_ch1", 3'd1, 1'b0, 4'd3, 1'b0);

        // Reset mid-read: valid high, then rst drops between edges.
        rd_req_i = 1'b1;
        rd_sel_i = 3'd0; rd_src_i = 1'b0;
        step(1);
        chk("pre_rst_valid", 64'(rd_valid_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rd_valid_o), 64'd0);
        chk("mid_rst_data",  64'(rd_data_o),  64'd0);
        chk("mid_rst_ovf",   64'(ovf_o),      64'd0);
        rd_req_i = 1'b0;
        step(1);
        #2 rst = 1'b1;
        step(1);
        chk("post_rst_valid", 64'(rd_valid_o), 64'd0);
        rd("post_rst_shd2", 3'd2, 1'b1, 4'd0, 1'b0);

        // Counting resumes on the first edge after release.
        event_i = 6'b000001;
        step(1);
        event_i = '0;
        rd("resume_ch0", 3'd0, 1'b0, 4'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
